// File: rtl/debug_pkg.sv
// Shared types and constants for the debug pattern transmitter.
// Holds the transmit FSM state encoding and the PRBS7 seed/tap definitions,
// plus the one-step LFSR update used by the generator.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        GAP      = 2'd3
    } tx_state_t;

    // PRBS7, x^7 + x^6 + 1, Fibonacci form shifting towards the MSB.
    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
    endfunction

endpackage

// File: rtl/debug_prbs7.sv
// PRBS7 bit source for the debug pattern transmitter.
// Ports: clk/rst_n (sync, active-low), reload (restart from seed), advance
// (consume one bit), prbs_bit (bit to transmit now).
//
// The transmitted bit comes from a one-bit output stage (bit_q) that is primed
// with the seed MSB and then follows lfsr[6] one step behind. From seed 7'h7F
// this yields the words 8'hFF, 8'h02, ... for an 8-bit frame.
// reload is bypassed combinationally so that the bit presented in a reload
// cycle is already the first bit of the restarted sequence; reload together
// with advance consumes that bit in the same cycle.
module debug_prbs7
    import debug_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic advance,
    output logic prbs_bit
);

    logic [6:0] lfsr;
    logic       bit_q;
    logic [6:0] src_lfsr;
    logic       src_bit;

    always_comb begin
        src_lfsr = lfsr;
        src_bit  = bit_q;
        if (reload) begin
            src_lfsr = PRBS7_SEED;
            src_bit  = PRBS7_SEED[6];
        end
    end

    assign prbs_bit = src_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr  <= PRBS7_SEED;
            bit_q <= PRBS7_SEED[6];
        end else if (advance) begin
            bit_q <= src_lfsr[6];
            lfsr  <= prbs7_next(src_lfsr);
        end else if (reload) begin
            bit_q <= PRBS7_SEED[6];
            lfsr  <= PRBS7_SEED;
        end
    end

endmodule

// File: rtl/debug_pattern_tx.sv
// Debug stimulus generator: forwarded slow clock plus serial test word (MSB first).
// Ports: clk, rst_n (sync, active-low); start/pattern/prbs_en/continuous control;
// busy/done status; out_clk/out_signal to the jumpers; led_clk/led_signal to LEDs.
//
// Timing: out_clk half-period is CLK_DIV clk cycles. out_signal only changes
// on the edge that drops out_clk (or at frame load, when out_clk is already
// low), so it is stable for a full low phase before every rising edge and
// through the whole high phase. First rising edge lands CLK_DIV+1 cycles after
// the cycle start is presented; one frame is 2*CLK_DIV*(WORD_W+GAP_PERIODS)
// cycles. done is decoded from the final gap tick, so it is high in the last
// busy cycle and busy is low from the following cycle.
// Assumes CLK_DIV >= 2, WORD_W >= 2, GAP_PERIODS >= 1, LED_DIV >= 1.
module debug_pattern_tx
    import debug_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int WORD_W      = 8,
    parameter int GAP_PERIODS = 2,
    parameter int LED_DIV     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] pattern,
    input  logic              prbs_en,
    input  logic              continuous,
    output logic              busy,
    output logic              done,
    output logic              out_clk,
    output logic              out_signal,
    output logic              led_clk,
    output logic              led_signal
);

    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int GAP_TICKS = 2 * GAP_PERIODS;
    localparam int GAP_W     = $clog2(GAP_TICKS + 1);
    localparam int LED_W     = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_DIV - 1);

    tx_state_t         state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_idx, bit_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [WORD_W-1:0] shreg, sh_nxt;
    logic [WORD_W-1:0] pat_q, pat_nxt;
    logic              prbs_mode, mode_nxt;
    logic              clk_nxt, sig_nxt;
    logic              ledclk_nxt, ledsig_nxt;
    logic [LED_W-1:0]  led_cnt, ledcnt_nxt;

    logic tick;
    logic led_rise;
    logic led_clr;
    logic prbs_adv;
    logic prbs_reload;
    logic prbs_bit;

    debug_prbs7 u_prbs (
        .clk      (clk),
        .rst_n    (rst_n),
        .reload   (prbs_reload),
        .advance  (prbs_adv),
        .prbs_bit (prbs_bit)
    );

    assign busy = (state != IDLE);
    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);
    // out_clk rises exactly on a SHIFT_LO tick; out_signal is already stable then.
    assign led_rise = (state == SHIFT_LO) && tick;

    // Next-state and next-output decode.
    always_comb begin
        state_nxt   = state;
        bit_nxt     = bit_idx;
        gap_nxt     = gap_cnt;
        sh_nxt      = shreg;
        pat_nxt     = pat_q;
        mode_nxt    = prbs_mode;
        clk_nxt     = out_clk;
        sig_nxt     = out_signal;
        prbs_adv    = 1'b0;
        prbs_reload = 1'b0;
        done        = 1'b0;
        led_clr     = 1'b0;

        case (state)
            IDLE: begin
                clk_nxt = 1'b0;
                sig_nxt = 1'b0;
                if (start) begin
                    pat_nxt   = pattern;
                    sh_nxt    = pattern;
                    mode_nxt  = prbs_en;
                    bit_nxt   = '0;
                    gap_nxt   = '0;
                    led_clr   = 1'b1;
                    state_nxt = SHIFT_LO;
                    if (prbs_en) begin
                        // Each transfer restarts the sequence from seed.
                        prbs_reload = 1'b1;
                        prbs_adv    = 1'b1;
                        sig_nxt     = prbs_bit;
                    end else begin
                        sig_nxt = pattern[WORD_W-1];
                    end
                end
            end

            SHIFT_LO: begin
                clk_nxt = 1'b0;
                if (tick) begin
                    clk_nxt   = 1'b1;
                    state_nxt = SHIFT_HI;
                end
            end

            SHIFT_HI: begin
                clk_nxt = 1'b1;
                if (tick) begin
                    clk_nxt = 1'b0;
                    if (bit_idx == BIT_LAST) begin
                        sig_nxt   = 1'b0;
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        bit_nxt   = bit_idx + BIT_W'(1);
                        sh_nxt    = {shreg[WORD_W-2:0], 1'b0};
                        sig_nxt   = prbs_mode ? prbs_bit : shreg[WORD_W-2];
                        prbs_adv  = prbs_mode;
                        state_nxt = SHIFT_LO;
                    end
                end
            end

            GAP: begin
                clk_nxt = 1'b0;
                sig_nxt = 1'b0;
                if (tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        if (continuous) begin
                            // PRBS carries on from its current state; fixed
                            // mode replays the word latched at start.
                            sh_nxt    = pat_q;
                            bit_nxt   = '0;
                            sig_nxt   = prbs_mode ? prbs_bit : pat_q[WORD_W-1];
                            prbs_adv  = prbs_mode;
                            state_nxt = SHIFT_LO;
                        end else begin
                            done      = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        gap_nxt = gap_cnt + GAP_W'(1);
                    end
                end
            end

            default: begin
                clk_nxt   = 1'b0;
                sig_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Divider runs only outside IDLE and wraps on the phase tick.
    always_comb begin
        div_nxt = div_cnt;
        if (state == IDLE) begin
            div_nxt = '0;
        end else if (tick) begin
            div_nxt = '0;
        end else begin
            div_nxt = div_cnt + DIV_W'(1);
        end
    end

    // LEDs: led_signal is sticky per transfer; led_clk counts out_clk rises
    // and keeps its count across transfers so the blink rate stays even.
    always_comb begin
        ledsig_nxt = led_signal;
        ledclk_nxt = led_clk;
        ledcnt_nxt = led_cnt;
        if (led_clr) begin
            ledsig_nxt = 1'b0;
        end else if (led_rise && out_signal) begin
            ledsig_nxt = 1'b1;
        end
        if (led_rise) begin
            if (led_cnt == LED_LAST) begin
                ledcnt_nxt = '0;
                ledclk_nxt = ~led_clk;
            end else begin
                ledcnt_nxt = led_cnt + LED_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            pat_q      <= '0;
            prbs_mode  <= 1'b0;
            out_clk    <= 1'b0;
            out_signal <= 1'b0;
            led_clk    <= 1'b0;
            led_cnt    <= '0;
            led_signal <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_idx    <= bit_nxt;
            gap_cnt    <= gap_nxt;
            shreg      <= sh_nxt;
            pat_q      <= pat_nxt;
            prbs_mode  <= mode_nxt;
            out_clk    <= clk_nxt;
            out_signal <= sig_nxt;
            led_clk    <= ledclk_nxt;
            led_cnt    <= ledcnt_nxt;
            led_signal <= ledsig_nxt;
        end
    end

endmodule
